// File: rtl/wb_sharedbus_arb.sv
// Wishbone shared-bus interconnect: N masters, M slaves, round-robin grant, mask/match decode, watchdog.
// Optional bus locking is compiled in with `define WB_SHAREDBUS_LOCK_EN.
module wb_sharedbus_arb #(
  parameter int             NUM_MASTERS = 2,
  parameter int             NUM_SLAVES  = 6,
  parameter logic [255:0]   SLAVE_ADDR  = {8{32'h0}},
  parameter logic [255:0]   SLAVE_MASK  = {8{32'h0}},
  parameter int             TIMEOUT     = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [32*NUM_MASTERS-1:0] m_adr_i,
  input  logic [32*NUM_MASTERS-1:0] m_dat_i,
  input  logic [4*NUM_MASTERS-1:0]  m_sel_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  input  logic [NUM_MASTERS-1:0]    m_lock_i,
  output logic [31:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [NUM_MASTERS-1:0]    m_err_o,
  output logic [NUM_MASTERS-1:0]    m_rty_o,
  output logic [31:0]               s_adr_o,
  output logic [31:0]               s_dat_o,
  output logic [3:0]                s_sel_o,
  output logic                      s_we_o,
  output logic [NUM_SLAVES-1:0]     s_cyc_o,
  output logic [NUM_SLAVES-1:0]     s_stb_o,
  input  logic [32*NUM_SLAVES-1:0]  s_dat_i,
  input  logic [NUM_SLAVES-1:0]     s_ack_i,
  input  logic [NUM_SLAVES-1:0]     s_err_i,
  input  logic [NUM_SLAVES-1:0]     s_rty_i
);

  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_nxt;
  logic [MW-1:0]   owner, owner_nxt;
  logic [MW-1:0]   last_grant, last_grant_nxt;
  logic [MW-1:0]   rr_idx;
  logic [SW-1:0]   sel;
  logic            hit;
  logic            busy;
  logic            owner_cyc, owner_stb, owner_hold;
  logic [31:0]     owner_adr;
  logic            slv_ack, slv_err, slv_rty, slv_any;
  logic            unmapped_req;
  logic            dec_err_q, dec_err_done;
  logic            stb_wait;
  logic [15:0]     wd_cnt;
  logic            wd_err_q;

  assign busy      = (state == BUSY);
  assign owner_cyc = m_cyc_i[owner];
  assign owner_stb = m_stb_i[owner];
  assign owner_adr = m_adr_i[32*owner +: 32];

`ifdef WB_SHAREDBUS_LOCK_EN
  assign owner_hold = owner_cyc | m_lock_i[owner];
`else
  logic lock_unused;
  assign lock_unused = ^m_lock_i;
  assign owner_hold  = owner_cyc;
`endif

  // First requester strictly after last_grant, wrapping around.
  always_comb begin
    int k;
    logic found;
    found  = 1'b0;
    rr_idx = last_grant;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      k = (int'(last_grant) + i) % NUM_MASTERS;
      if (!found && m_cyc_i[k]) begin
        found  = 1'b1;
        rr_idx = MW'(k);
      end
    end
  end

  // Lowest-index matching window wins when windows overlap.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (!hit && ((owner_adr & SLAVE_MASK[32*i +: 32]) == SLAVE_ADDR[32*i +: 32])) begin
        hit = 1'b1;
        sel = SW'(i);
      end
    end
  end

  assign slv_ack = hit & s_ack_i[sel];
  assign slv_err = hit & s_err_i[sel];
  assign slv_rty = hit & s_rty_i[sel];
  assign slv_any = slv_ack | slv_err | slv_rty;

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (|m_cyc_i) begin
          state_nxt = BUSY;
          owner_nxt = rr_idx;
        end
      end
      BUSY: begin
        if (!owner_hold) begin
          state_nxt      = IDLE;
          last_grant_nxt = owner;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= '0;
      last_grant <= MW'(NUM_MASTERS - 1);
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Unmapped access: one err pulse per strobe episode, even if stb is held.
  assign unmapped_req = busy & owner_cyc & owner_stb & ~hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_err_q    <= 1'b0;
      dec_err_done <= 1'b0;
    end else begin
      dec_err_q    <= unmapped_req & ~dec_err_q & ~dec_err_done;
      dec_err_done <= unmapped_req & (dec_err_q | dec_err_done);
    end
  end

  // Watchdog; cnt+1 can never equal 0, so TIMEOUT=0 leaves it disabled.
  assign stb_wait = busy & owner_cyc & owner_stb & ~slv_any & ~dec_err_q & ~wd_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt   <= '0;
      wd_err_q <= 1'b0;
    end else if (!stb_wait) begin
      wd_cnt   <= '0;
      wd_err_q <= 1'b0;
    end else if (({1'b0, wd_cnt} + 17'd1) == 17'(TIMEOUT)) begin
      wd_cnt   <= '0;
      wd_err_q <= 1'b1;
    end else begin
      wd_cnt   <= wd_cnt + 16'd1;
      wd_err_q <= 1'b0;
    end
  end

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = '0;
    s_stb_o = '0;
    m_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    if (busy) begin
      s_adr_o = owner_adr;
      s_dat_o = m_dat_i[32*owner +: 32];
      s_sel_o = m_sel_i[4*owner +: 4];
      s_we_o  = m_we_i[owner];
      if (hit) begin
        s_cyc_o[sel] = owner_cyc;
        s_stb_o[sel] = owner_stb;
        m_dat_o      = s_dat_i[32*sel +: 32];
      end
      // A response arriving after the owner dropped cyc is discarded.
      if (owner_cyc) begin
        m_ack_o[owner] = slv_ack;
        m_rty_o[owner] = slv_rty;
        m_err_o[owner] = slv_err | dec_err_q | (wd_err_q & ~slv_any);
      end
    end
  end

endmodule

// File: tb/tb_wb_sharedbus_arb.sv
// Scoreboard bench for wb_sharedbus_arb: 2 masters, 3 slaves (bram, uart, sram), TIMEOUT=16.
module tb_wb_sharedbus_arb;

  localparam int NM = 2;
  localparam int NS = 3;
  localparam logic [255:0] ADDRS = {160'h0, 32'h4000_0000, 32'hE000_0000, 32'h0000_0000};
  localparam logic [255:0] MASKS = {160'h0, 32'hFFF0_0000, 32'hFFFF_0000, 32'hFFFF_8000};
  localparam logic [NS*32-1:0] SDAT = {32'h5A5A_1234, 32'h0000_00A5, 32'hB7A4_0000};

  logic              clk;
  logic              rst_n;
  logic [32*NM-1:0]  m_adr_i, m_dat_i;
  logic [4*NM-1:0]   m_sel_i;
  logic [NM-1:0]     m_we_i, m_cyc_i, m_stb_i, m_lock_i;
  logic [31:0]       m_dat_o;
  logic [NM-1:0]     m_ack_o, m_err_o, m_rty_o;
  logic [31:0]       s_adr_o, s_dat_o;
  logic [3:0]        s_sel_o;
  logic              s_we_o;
  logic [NS-1:0]     s_cyc_o, s_stb_o;
  logic [32*NS-1:0]  s_dat_i;
  logic [NS-1:0]     s_ack_i, s_err_i, s_rty_i;

  wb_sharedbus_arb #(
    .NUM_MASTERS(NM), .NUM_SLAVES(NS), .SLAVE_ADDR(ADDRS), .SLAVE_MASK(MASKS), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_lock_i(m_lock_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Per-master drive variables, flattened onto the DUT ports.
  logic [31:0] madr [NM];
  logic [31:0] mdat [NM];
  logic        mwe  [NM];
  logic        mcyc [NM];
  logic        mstb [NM];
  logic        mlock[NM];
  int          req_cyc[NM];

  always_comb begin
    for (int i = 0; i < NM; i++) begin
      m_adr_i[32*i +: 32] = madr[i];
      m_dat_i[32*i +: 32] = mdat[i];
      m_sel_i[4*i +: 4]   = 4'hF;
      m_we_i[i]           = mwe[i];
      m_cyc_i[i]          = mcyc[i];
      m_stb_i[i]          = mstb[i];
      m_lock_i[i]         = mlock[i];
    end
  end

  // Slave models: respond after slat[j] strobe cycles; kind 0=ack 1=err 2=rty; 255 = never.
  int slat [NS];
  int skind[NS];
  int scnt [NS];
  assign s_dat_i = SDAT;

  always @(posedge clk)
    for (int j = 0; j < NS; j++) scnt[j] <= (s_cyc_o[j] && s_stb_o[j]) ? scnt[j] + 1 : 0;

  always_comb begin
    for (int j = 0; j < NS; j++) begin
      s_ack_i[j] = s_cyc_o[j] && s_stb_o[j] && (scnt[j] == slat[j]) && (skind[j] == 0);
      s_err_i[j] = s_cyc_o[j] && s_stb_o[j] && (scnt[j] == slat[j]) && (skind[j] == 1);
      s_rty_i[j] = s_cyc_o[j] && s_stb_o[j] && (scnt[j] == slat[j]) && (skind[j] == 2);
    end
  end

  typedef struct {
    int            m;
    logic [NM-1:0] ack, err, rty;
    logic [NS-1:0] stb;
    logic [31:0]   adr;
    logic          chk_dat;
    logic [31:0]   dat;
    int            lat;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_resp(input int m, input int kind, input logic [NS-1:0] stb,
                             input logic [31:0] adr, input logic chkd, input logic [31:0] dat,
                             input int lat);
    exp_t e;
    e.m       = m;
    e.ack     = (kind == 0) ? (NM'(1) << m) : '0;
    e.err     = (kind == 1) ? (NM'(1) << m) : '0;
    e.rty     = (kind == 2) ? (NM'(1) << m) : '0;
    e.stb     = stb;
    e.adr     = adr;
    e.chk_dat = chkd;
    e.dat     = dat;
    e.lat     = lat;
    sbq.push_back(e);
  endtask

  // Monitor: every presented response is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && ((|m_ack_o) || (|m_err_o) || (|m_rty_o))) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: ack=%b err=%b rty=%b but none expected", m_ack_o, m_err_o, m_rty_o);
      end else begin
        mon_e = sbq.pop_front();
        chk("resp_vector", 64'({m_ack_o, m_err_o, m_rty_o}), 64'({mon_e.ack, mon_e.err, mon_e.rty}));
        chk("slave_stb", 64'(s_stb_o), 64'(mon_e.stb));
        chk("slave_adr", 64'(s_adr_o), 64'(mon_e.adr));
        if (mon_e.chk_dat) chk("read_data", 64'(m_dat_o), 64'(mon_e.dat));
        if (mon_e.lat >= 0) chk("latency", 64'(cyc_cnt - req_cyc[mon_e.m]), 64'(mon_e.lat));
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_slave_ctl"}, 64'({s_cyc_o, s_stb_o, s_we_o, s_sel_o}), 64'(0));
    chk({tag, "_slave_bus"}, {s_adr_o, s_dat_o}, 64'(0));
    chk({tag, "_master_resp"}, 64'({m_ack_o, m_err_o, m_rty_o}), 64'(0));
    chk({tag, "_master_dat"}, 64'(m_dat_o), 64'(0));
  endtask

  task automatic xfer(input int m, input logic [31:0] a, input logic we,
                      input logic [31:0] d, input int hold);
    logic got;
    @(posedge clk); #1;
    madr[m] = a; mdat[m] = d; mwe[m] = we; mcyc[m] = 1'b1; mstb[m] = 1'b1;
    req_cyc[m] = cyc_cnt;
    got = 1'b0;
    for (int n = 0; n < 64 && !got; n++) begin
      @(negedge clk);
      got = m_ack_o[m] | m_err_o[m] | m_rty_o[m];
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL xfer_timeout: master %0d adr %h got no response, required one", m, a);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("err_held_low", 64'(m_err_o[m]), 64'(0));
    end
    @(posedge clk); #1;
    mcyc[m] = 1'b0; mstb[m] = 1'b0; mwe[m] = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NM; i++) begin
      madr[i] = '0; mdat[i] = '0; mwe[i] = 0; mcyc[i] = 0; mstb[i] = 0; mlock[i] = 0; req_cyc[i] = 0;
    end
    for (int j = 0; j < NS; j++) begin
      slat[j] = 0; skind[j] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("idle");

    // Round robin with both masters requesting: 0,1,0,1.
    expect_resp(0, 0, 3'b001, 32'h0000_0010, 1'b1, 32'hB7A4_0000, 1);
    expect_resp(1, 0, 3'b001, 32'h0000_0020, 1'b1, 32'hB7A4_0000, -1);
    expect_resp(0, 0, 3'b001, 32'h0000_0014, 1'b1, 32'hB7A4_0000, -1);
    expect_resp(1, 0, 3'b001, 32'h0000_0024, 1'b1, 32'hB7A4_0000, -1);
    fork
      begin xfer(0, 32'h0000_0010, 1'b0, 32'h0, 0); xfer(0, 32'h0000_0014, 1'b0, 32'h0, 0); end
      begin xfer(1, 32'h0000_0020, 1'b0, 32'h0, 0); xfer(1, 32'h0000_0024, 1'b0, 32'h0, 0); end
    join

    // Decode: uart read, bram top-of-window write with 2-cycle slave, sram read, uart retry.
    expect_resp(0, 0, 3'b010, 32'hE000_0004, 1'b1, 32'h0000_00A5, 1);
    xfer(0, 32'hE000_0004, 1'b0, 32'h0, 0);
    slat[0] = 2;
    expect_resp(1, 0, 3'b001, 32'h0000_7FFC, 1'b0, 32'h0, 3);
    xfer(1, 32'h0000_7FFC, 1'b1, 32'h1234_5678, 0);
    slat[0] = 0;
    expect_resp(0, 0, 3'b100, 32'h4000_0008, 1'b1, 32'h5A5A_1234, 1);
    xfer(0, 32'h4000_0008, 1'b0, 32'h0, 0);
    skind[1] = 2;
    expect_resp(1, 2, 3'b010, 32'hE000_0010, 1'b0, 32'h0, 1);
    xfer(1, 32'hE000_0010, 1'b0, 32'h0, 0);
    skind[1] = 0;

    // Unmapped: one err pulse the cycle after stb, held stb gets no second pulse.
    expect_resp(1, 1, 3'b000, 32'h3000_0000, 1'b0, 32'h0, 2);
    xfer(1, 32'h3000_0000, 1'b0, 32'h0, 4);
    expect_resp(0, 1, 3'b000, 32'h0000_8000, 1'b0, 32'h0, 2);
    xfer(0, 32'h0000_8000, 1'b0, 32'h0, 0);

    // Watchdog: dead slave gives err 16 cycles after stb; ack on that cycle wins.
    slat[2] = 255;
    expect_resp(0, 1, 3'b100, 32'h4000_0010, 1'b0, 32'h0, 17);
    xfer(0, 32'h4000_0010, 1'b0, 32'h0, 0);
    slat[2] = 16;
    expect_resp(0, 0, 3'b100, 32'h4000_0014, 1'b1, 32'h5A5A_1234, 17);
    xfer(0, 32'h4000_0014, 1'b0, 32'h0, 0);

    // Reset in the middle of a stalled sram write.
    slat[2] = 255;
    @(posedge clk); #1;
    madr[0] = 32'h4000_0020; mdat[0] = 32'hDEAD_BEEF; mwe[0] = 1'b1; mcyc[0] = 1'b1; mstb[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_reset_slave", 64'({s_stb_o, s_we_o, s_dat_o}), 64'({3'b100, 1'b1, 32'hDEAD_BEEF}));
    #2 rst_n = 1'b0;
    #1 chk_all_zero("mid_reset");
    mcyc[0] = 1'b0; mstb[0] = 1'b0; mwe[0] = 1'b0;
    slat[2] = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    expect_resp(1, 0, 3'b100, 32'h4000_0024, 1'b1, 32'h5A5A_1234, 1);
    xfer(1, 32'h4000_0024, 1'b0, 32'h0, 0);

`ifdef WB_SHAREDBUS_LOCK_EN
    // Locked m0 keeps the bus across its cyc gap; m1 waits for the lock to drop.
    expect_resp(0, 0, 3'b001, 32'h0000_0040, 1'b1, 32'hB7A4_0000, -1);
    expect_resp(0, 0, 3'b001, 32'h0000_0044, 1'b1, 32'hB7A4_0000, -1);
    expect_resp(1, 0, 3'b001, 32'h0000_0048, 1'b1, 32'hB7A4_0000, -1);
    fork
      begin
        mlock[0] = 1'b1;
        xfer(0, 32'h0000_0040, 1'b0, 32'h0, 0);
        xfer(0, 32'h0000_0044, 1'b0, 32'h0, 0);
        @(posedge clk); #1 mlock[0] = 1'b0;
      end
      begin xfer(1, 32'h0000_0048, 1'b0, 32'h0, 0); end
    join
`endif

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", 64'(sbq.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
